// File: rtl/clkgen_ctrl.sv
// Programmable glitch-free bus clock sequencer: emits N periods or a continuous clock,
// with lead/trail edge strobes and divider updates applied only at period boundaries.
module clkgen_ctrl #(
    parameter int unsigned MAIN_CLK_HZ = 50_000_000,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DIV_DEFAULT = 2499,
    parameter logic        CLK_IDLE    = 1'b0
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic [DIV_WIDTH-1:0] in_div,
    input  logic                 in_cfg_valid,
    output logic                 out_cfg_ready,
    input  logic                 in_start,
    input  logic [CNT_WIDTH-1:0] in_count,
    input  logic                 in_stop,
    output logic                 out_clk,
    output logic                 out_lead,
    output logic                 out_trail,
    output logic                 out_busy,
    output logic                 out_done
);

    if (MAIN_CLK_HZ < 2) begin : g_bad_main_clk
        $error("clkgen_ctrl: MAIN_CLK_HZ must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REST   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] div_next;
    logic [DIV_WIDTH-1:0] ctr;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] period_inc;
    logic                 pending;
    logic                 stop_req;

    logic cfg_xfer;
    logic half_end;
    logic period_end;
    logic burst_end;

    logic clk_d;
    logic lead_d;
    logic trail_d;
    logic done_d;
    logic busy_d;

    assign out_cfg_ready = ~pending;
    assign cfg_xfer      = in_cfg_valid && !pending;
    assign half_end      = (ctr == div_reg);
    assign period_end    = (state == REST) && half_end;
    assign period_inc    = period_cnt + 1'b1;

    // A stop arriving on the boundary cycle itself still ends the burst there.
    assign burst_end = stop_req || in_stop ||
                       ((count_reg != '0) && (period_inc == count_reg));

    // State register and all datapath/output registers
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state      <= IDLE;
            ctr        <= '0;
            period_cnt <= '0;
            count_reg  <= '0;
            div_reg    <= DIV_WIDTH'(DIV_DEFAULT);
            div_next   <= DIV_WIDTH'(DIV_DEFAULT);
            pending    <= 1'b0;
            stop_req   <= 1'b0;
            out_clk    <= CLK_IDLE;
            out_lead   <= 1'b0;
            out_trail  <= 1'b0;
            out_done   <= 1'b0;
            out_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_clk   <= clk_d;
            out_lead  <= lead_d;
            out_trail <= trail_d;
            out_done  <= done_d;
            out_busy  <= busy_d;

            if ((state_nxt == state) && (state != IDLE)) begin
                ctr <= ctr + 1'b1;
            end else begin
                ctr <= '0;
            end

            if ((state == IDLE) && in_start) begin
                count_reg  <= in_count;
                period_cnt <= '0;
            end else if (period_end) begin
                period_cnt <= period_inc;
            end

            // Deferred value lands exactly at the boundary, so no period is ever resized.
            if (period_end && pending) begin
                div_reg <= div_next;
                pending <= 1'b0;
            end
            if (cfg_xfer) begin
                if ((state == IDLE) || period_end) begin
                    div_reg <= in_div;
                end else begin
                    div_next <= in_div;
                    pending  <= 1'b1;
                end
            end

            if (state_nxt == IDLE) begin
                stop_req <= 1'b0;
            end else if (in_stop && (state != IDLE)) begin
                stop_req <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_start) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (half_end) begin
                    state_nxt = REST;
                end
            end
            REST: begin
                if (half_end) begin
                    state_nxt = burst_end ? IDLE : ACTIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, keeping out_clk glitch-free.
    always_comb begin
        clk_d   = (state_nxt == ACTIVE) ? ~CLK_IDLE : CLK_IDLE;
        lead_d  = (state_nxt == ACTIVE) && (state != ACTIVE);
        trail_d = (state == ACTIVE) && (state_nxt == REST);
        done_d  = (state == REST) && (state_nxt == IDLE);
        busy_d  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed bench for clkgen_ctrl: burst timing, continuous mode, stop, config handshake, reset.
module tb_clkgen_ctrl;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_WIDTH = 16;

    logic                 in_clk;
    logic                 in_rst_n;
    logic [DIV_WIDTH-1:0] in_div;
    logic                 in_cfg_valid;
    logic                 out_cfg_ready;
    logic                 in_start;
    logic [CNT_WIDTH-1:0] in_count;
    logic                 in_stop;
    logic                 out_clk;
    logic                 out_lead;
    logic                 out_trail;
    logic                 out_busy;
    logic                 out_done;

    int checks = 0;
    int errors = 0;

    clkgen_ctrl #(
        .MAIN_CLK_HZ(50_000_000),
        .DIV_WIDTH  (DIV_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .DIV_DEFAULT(4),
        .CLK_IDLE   (1'b0)
    ) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_div       (in_div),
        .in_cfg_valid (in_cfg_valid),
        .out_cfg_ready(out_cfg_ready),
        .in_start     (in_start),
        .in_count     (in_count),
        .in_stop      (in_stop),
        .out_clk      (out_clk),
        .out_lead     (out_lead),
        .out_trail    (out_trail),
        .out_busy     (out_busy),
        .out_done     (out_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic cfg_idle(input logic [DIV_WIDTH-1:0] d);
        in_div       = d;
        in_cfg_valid = 1'b1;
        step();
        in_cfg_valid = 1'b0;
        chk("idle_cfg_ready", 0, out_cfg_ready, 1'b1);
    endtask

    initial begin
        in_rst_n     = 1'b0;
        in_div       = '0;
        in_cfg_valid = 1'b0;
        in_start     = 1'b0;
        in_count     = '0;
        in_stop      = 1'b0;
        step();
        step();
        chk("rst_clk",   0, out_clk,       1'b0);
        chk("rst_busy",  0, out_busy,      1'b0);
        chk("rst_done",  0, out_done,      1'b0);
        chk("rst_lead",  0, out_lead,      1'b0);
        chk("rst_trail", 0, out_trail,     1'b0);
        chk("rst_ready", 0, out_cfg_ready, 1'b1);
        in_rst_n = 1'b1;
        step();

        // Two-period burst, div=1; start+stop together, restart mid-burst, stop in IDLE
        cfg_idle(16'd1);
        in_start = 1'b1;
        in_stop  = 1'b1;
        in_count = 16'd2;
        step();
        in_start = 1'b0;
        in_stop  = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            chk("b2_clk",   i, out_clk,   (i == 1 || i == 2 || i == 5 || i == 6));
            chk("b2_lead",  i, out_lead,  (i == 1 || i == 5));
            chk("b2_trail", i, out_trail, (i == 3 || i == 7));
            chk("b2_busy",  i, out_busy,  (i <= 8));
            chk("b2_done",  i, out_done,  (i == 9));
            in_start = (i == 3);
            in_stop  = (i == 9);
            step();
        end
        in_stop = 1'b0;
        chk("idle_stop_clk",  10, out_clk,  1'b0);
        chk("idle_stop_busy", 10, out_busy, 1'b0);
        chk("idle_stop_done", 10, out_done, 1'b0);
        step();

        // Continuous at in_clk/2, stop during the high half
        cfg_idle(16'd0);
        in_start = 1'b1;
        in_count = 16'd0;
        step();
        in_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("cont_clk",   i, out_clk,   (i <= 6) && (i % 2 == 1));
            chk("cont_lead",  i, out_lead,  (i <= 6) && (i % 2 == 1));
            chk("cont_trail", i, out_trail, (i <= 6) && (i % 2 == 0));
            chk("cont_busy",  i, out_busy,  (i <= 6));
            chk("cont_done",  i, out_done,  (i == 7));
            in_stop = (i == 5);
            step();
        end
        in_stop = 1'b0;

        // Divider change 3 -> 1 while running, then stop
        cfg_idle(16'd3);
        in_start = 1'b1;
        in_count = 16'd0;
        step();
        in_start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            chk("dchg_clk",   i, out_clk,
                (i <= 4) || (i == 9) || (i == 10) || (i == 13) || (i == 14));
            chk("dchg_ready", i, out_cfg_ready, (i <= 2) || (i >= 9));
            chk("dchg_busy",  i, out_busy,  (i <= 16));
            chk("dchg_done",  i, out_done,  (i == 17));
            in_cfg_valid = (i == 2);
            in_div       = 16'd1;
            in_stop      = (i == 13);
            step();
        end
        in_cfg_valid = 1'b0;
        in_stop      = 1'b0;

        // Reset mid-ACTIVE with a pending config
        cfg_idle(16'd3);
        in_start = 1'b1;
        in_count = 16'd0;
        step();
        in_start = 1'b0;
        chk("rmid_clk_c1", 1, out_clk, 1'b1);
        in_div       = 16'd1;
        in_cfg_valid = 1'b1;
        step();
        in_cfg_valid = 1'b0;
        chk("rmid_pending", 2, out_cfg_ready, 1'b0);
        in_rst_n = 1'b0;
        step();
        in_rst_n = 1'b1;
        chk("rmid_clk",   3, out_clk,       1'b0);
        chk("rmid_busy",  3, out_busy,      1'b0);
        chk("rmid_ready", 3, out_cfg_ready, 1'b1);
        chk("rmid_done",  3, out_done,      1'b0);
        step();
        chk("rmid_done2", 4, out_done, 1'b0);
        in_start = 1'b1;
        in_count = 16'd1;
        step();
        in_start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            chk("dflt_clk",  i, out_clk,  (i <= 5));
            chk("dflt_busy", i, out_busy, (i <= 10));
            chk("dflt_done", i, out_done, (i == 11));
            step();
        end

        // Single period with stop in the same final period
        cfg_idle(16'd1);
        in_start = 1'b1;
        in_count = 16'd1;
        step();
        in_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("one_clk",   i, out_clk,   (i <= 2));
            chk("one_lead",  i, out_lead,  (i == 1));
            chk("one_trail", i, out_trail, (i == 3));
            chk("one_busy",  i, out_busy,  (i <= 4));
            chk("one_done",  i, out_done,  (i == 5));
            in_stop = (i == 3);
            step();
        end
        in_stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
